// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Latches the EX outputs, runs the split
// address/data handshake to the data bus bridge, aligns lanes and flags AdEL/AdES.
module mem_stage #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] aluout,
   input  logic [31:0] mem_write_data,
   input  logic [4:0]  writereg,
   input  logic [31:0] pc,
   input  logic [5:0]  opE,
   input  logic [3:0]  controls,
   input  logic [7:0]  exception_code,
   input  logic        is_in_slot,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic [31:0] resultM,
   output logic [4:0]  writeregM,
   output logic        regwriteM,
   output logic [31:0] pcM,
   output logic [7:0]  exception_codeM,
   output logic [31:0] badvaddrM,
   output logic        is_in_slotM,
   output logic        stall_mem
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

   logic [31:0] aluout_p0, wdata_p0, pc_p0;
   logic [4:0]  writereg_p0;
   logic [5:0]  op_p0;
   logic [3:1]  ctrl_p0;
   logic [7:0]  exc_p0;
   logic        slot_p0;

   // The cp0/hilo passthrough bit has no consumer inside this stage.
   logic unused_cp0;
   assign unused_cp0 = controls[0];

   // ---- EX -> MEM stage registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         aluout_p0   <= '0;
         wdata_p0    <= '0;
         pc_p0       <= RESET_PC;
         writereg_p0 <= '0;
         op_p0       <= '0;
         ctrl_p0     <= '0;
         exc_p0      <= '0;
         slot_p0     <= 1'b0;
      end else if (flush) begin
         aluout_p0   <= '0;
         wdata_p0    <= '0;
         pc_p0       <= RESET_PC;
         writereg_p0 <= '0;
         op_p0       <= '0;
         ctrl_p0     <= '0;
         exc_p0      <= '0;
      end else if (!stall) begin
         aluout_p0   <= aluout;
         wdata_p0    <= mem_write_data;
         pc_p0       <= pc;
         writereg_p0 <= writereg;
         op_p0       <= opE;
         ctrl_p0     <= controls[3:1];
         exc_p0      <= exception_code;
         slot_p0     <= is_in_slot;
      end
   end

   logic       memtoreg, memwrite, regwrite;
   logic       is_load, is_store, sext;
   logic [1:0] size;
   logic       misalign, adel, ades, addr_err, access;

   assign memtoreg = ctrl_p0[3];
   assign memwrite = ctrl_p0[2];
   assign regwrite = ctrl_p0[1];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      sext     = 1'b0;
      size     = 2'd2;
      case (op_p0)
         6'b100000: begin is_load  = 1'b1; size = 2'd0; sext = 1'b1; end
         6'b100100: begin is_load  = 1'b1; size = 2'd0; end
         6'b100001: begin is_load  = 1'b1; size = 2'd1; sext = 1'b1; end
         6'b100101: begin is_load  = 1'b1; size = 2'd1; end
         6'b100011: begin is_load  = 1'b1; size = 2'd2; end
         6'b101000: begin is_store = 1'b1; size = 2'd0; end
         6'b101001: begin is_store = 1'b1; size = 2'd1; end
         6'b101011: begin is_store = 1'b1; size = 2'd2; end
         default: ;
      endcase
   end

   assign misalign = ((size == 2'd1) && aluout_p0[0]) || ((size == 2'd2) && (aluout_p0[1:0] != 2'b00));
   assign adel     = memtoreg && is_load  && misalign;
   assign ades     = memwrite && is_store && misalign;
   assign addr_err = adel || ades;
   assign access   = (memtoreg || memwrite) && (is_load || is_store) && (exc_p0 == 8'd0) && !addr_err;

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (sz)
         2'd0:    load_ext = {{24{sx & b[7]}}, b};
         2'd1:    load_ext = {{16{sx & h[15]}}, h};
         default: load_ext = w;
      endcase
   endfunction

   state_t      state;
   logic [31:0] rdata_buf;
   logic        resp_done;

   // Response that completes the live access this cycle (also covers addr_ok+data_ok together).
   assign resp_done = data_data_ok && ((state == S_WAIT) || ((state == S_REQ) && data_addr_ok));

   // ---- bus handshake FSM ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (access && !flush) state <= S_REQ;
            S_REQ: begin
               if (data_addr_ok) begin
                  if (data_data_ok) state <= (flush || !stall) ? S_IDLE : S_DONE;
                  else              state <= flush ? S_DRAIN : S_WAIT;
               end else if (flush) begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (data_data_ok) state <= (flush || !stall) ? S_IDLE : S_DONE;
               else if (flush)   state <= S_DRAIN;
            end
            S_DONE:  if (flush || !stall) state <= S_IDLE;
            S_DRAIN: if (data_data_ok) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resp_done) rdata_buf <= data_rdata;
   end

   assign data_req   = (state == S_REQ);
   assign data_wr    = is_store;
   assign data_size  = size;
   assign data_addr  = aluout_p0;

   always_comb begin
      data_wstrb = 4'b0000;
      case (size)
         2'd0:    data_wdata = {4{wdata_p0[7:0]}};
         2'd1:    data_wdata = {2{wdata_p0[15:0]}};
         default: data_wdata = wdata_p0;
      endcase
      if (is_store) begin
         case (size)
            2'd0:    data_wstrb = 4'b0001 << aluout_p0[1:0];
            2'd1:    data_wstrb = aluout_p0[1] ? 4'b1100 : 4'b0011;
            default: data_wstrb = 4'b1111;
         endcase
      end
   end

   logic [31:0] load_word;
   assign load_word = (state == S_DONE) ? rdata_buf : data_rdata;

   assign resultM         = memtoreg ? load_ext(load_word, aluout_p0[1:0], size, sext) : aluout_p0;
   assign writeregM       = writereg_p0;
   assign regwriteM       = regwrite && !addr_err;
   assign pcM             = pc_p0;
   assign is_in_slotM     = slot_p0;
   assign exception_codeM = exc_p0 | {1'b0, ades, adel, 5'b00000};
   assign badvaddrM       = addr_err ? aluout_p0 : 32'd0;
   assign stall_mem       = (access && (state != S_DONE) && !resp_done) || (state == S_DRAIN);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a latency-programmable
// SRAM-like bus responder; hazard stall modelled as stall_mem | ext_stall.
module tb_mem_stage;
   localparam logic [31:0] RPC = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        ext_stall = 1'b0;
   logic        stall;
   logic [31:0] aluout = '0, mem_write_data = '0, pc = '0;
   logic [4:0]  writereg = '0;
   logic [5:0]  opE = '0;
   logic [3:0]  controls = '0;
   logic [7:0]  exception_code = '0;
   logic        is_in_slot = 1'b0;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;
   logic [31:0] resultM, pcM, badvaddrM;
   logic [4:0]  writeregM;
   logic        regwriteM, is_in_slotM, stall_mem;
   logic [7:0]  exception_codeM;

   assign stall = stall_mem | ext_stall;

   mem_stage #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .aluout(aluout), .mem_write_data(mem_write_data), .writereg(writereg), .pc(pc),
      .opE(opE), .controls(controls), .exception_code(exception_code), .is_in_slot(is_in_slot),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .resultM(resultM), .writeregM(writeregM), .regwriteM(regwriteM), .pcM(pcM),
      .exception_codeM(exception_codeM), .badvaddrM(badvaddrM), .is_in_slotM(is_in_slotM),
      .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   // Bus responder: addr_ok after addr_lat extra request cycles, data_ok data_lat cycles later.
   int          addr_lat = 0, data_lat = 1;
   logic [31:0] resp = '0;
   int          rcnt = 0, dcnt = 0, n_acc = 0, n_reqcyc = 0;
   bit          pend = 0, prev_req = 0;
   logic [31:0] acc_addr = '0, acc_wdata = '0;
   logic [3:0]  acc_wstrb = '0;
   logic [1:0]  acc_size = '0;
   logic        acc_wr = 1'b0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         pend = 0; rcnt = 0; prev_req = 0;
         data_addr_ok = 1'b0; data_data_ok = 1'b0;
      end else begin
         if (prev_req && data_addr_ok) begin pend = 1; dcnt = 0; end
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         data_rdata   = 32'h5a5a5a5a;
         if (pend) begin
            dcnt++;
            if (dcnt >= data_lat) begin data_data_ok = 1'b1; data_rdata = resp; pend = 0; end
         end
         if (data_req) begin
            n_reqcyc++;
            if (rcnt >= addr_lat) begin
               data_addr_ok = 1'b1; rcnt = 0; n_acc++;
               acc_addr = data_addr; acc_wdata = data_wdata; acc_wstrb = data_wstrb;
               acc_size = data_size; acc_wr = data_wr;
            end else rcnt++;
         end else rcnt = 0;
         prev_req = data_req;
      end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   typedef struct {
      logic [31:0] res;
      bit          cr;
      logic [4:0]  wreg;
      logic        rw;
      logic [7:0]  exc;
      logic [31:0] badv;
      logic [31:0] pc;
      logic        slot;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] pc_ctr = 32'h80000100;
   logic [4:0]  wreg_ctr = 5'd1;
   int          tot_acc = 0;

   task automatic drive_bubble();
      aluout = '0; mem_write_data = '0; writereg = '0; pc = '0;
      opE = '0; controls = '0; exception_code = '0; is_in_slot = 1'b0;
   endtask

   // Drives one EX result, pushes its expected MEM view, then follows it to retirement.
   task automatic do_op(input string nm, input logic [5:0] op, input logic [3:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] exc_in,
                        input logic [31:0] rresp, input int a_lat, input int d_lat,
                        input bit cr, input logic [31:0] x_res, input logic [7:0] x_exc,
                        input logic x_rw, input int x_nacc, input logic [3:0] x_wstrb,
                        input logic [31:0] x_wdata, input int hold_n, input bit fl);
      exp_t e, g;
      int   acc0, rc0, lat, h, x_lat;
      bit   done, fl_done;
      logic slot_in;
      logic [1:0] x_size;
      pc_ctr   = pc_ctr + 32'd4;
      wreg_ctr = wreg_ctr + 5'd1;
      slot_in  = wreg_ctr[0] | fl;
      x_size   = (op[1:0] == 2'b00) ? 2'd0 : (op[1:0] == 2'b01) ? 2'd1 : 2'd2;
      x_lat    = (x_nacc == 0) ? 1 : (2 + a_lat + d_lat + hold_n + (fl ? 1 : 0));
      if (fl) begin
         e.res = 32'd0; e.cr = 1; e.wreg = 5'd0; e.rw = 1'b0; e.exc = 8'd0;
         e.badv = 32'd0; e.pc = RPC; e.slot = 1'b1;
      end else begin
         e.res = x_res; e.cr = cr; e.wreg = wreg_ctr; e.rw = x_rw; e.exc = x_exc;
         e.badv = ((x_exc & 8'h60) != 8'd0) ? addr : 32'd0; e.pc = pc_ctr; e.slot = slot_in;
      end
      addr_lat = a_lat; data_lat = d_lat; resp = rresp;
      aluout = addr; mem_write_data = wd; writereg = wreg_ctr; pc = pc_ctr;
      opE = op; controls = ctrl; exception_code = exc_in; is_in_slot = slot_in;
      sbq.push_back(e);
      tot_acc += x_nacc;
      acc0 = n_acc; rc0 = n_reqcyc;
      @(posedge clk); #2;
      drive_bubble();
      lat = 0; h = 0; done = 0; fl_done = 0;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
         flush = 1'b0;
         if (fl && !fl_done && pend && !data_data_ok) begin
            flush = 1'b1; fl_done = 1;
         end else if (fl_done && data_data_ok) begin
            check_eq({nm, ".drain_stall"}, 32'(stall_mem), 32'd1);
         end
         if (hold_n > 0 && h == 0 && !ext_stall && data_data_ok) begin
            ext_stall = 1'b1;
         end else if (ext_stall) begin
            check_eq({nm, ".hold_res"}, resultM, x_res);
            check_eq({nm, ".hold_req"}, 32'(data_req), 32'd0);
            h++;
            if (h >= hold_n) ext_stall = 1'b0;
         end
         if (!stall_mem && !ext_stall) begin
            g = sbq.pop_front();
            if (g.cr) check_eq({nm, ".res"}, resultM, g.res);
            check_eq({nm, ".wreg"}, 32'(writeregM), 32'(g.wreg));
            check_eq({nm, ".rw"}, 32'(regwriteM), 32'(g.rw));
            check_eq({nm, ".exc"}, 32'(exception_codeM), 32'(g.exc));
            check_eq({nm, ".badv"}, badvaddrM, g.badv);
            check_eq({nm, ".pc"}, pcM, g.pc);
            check_eq({nm, ".slot"}, 32'(is_in_slotM), 32'(g.slot));
            check_eq({nm, ".lat"}, 32'(lat), 32'(x_lat));
            check_eq({nm, ".nacc"}, 32'(n_acc - acc0), 32'(x_nacc));
            check_eq({nm, ".reqcyc"}, 32'(n_reqcyc - rc0), (x_nacc == 0) ? 32'd0 : 32'(a_lat + 1));
            if (x_nacc != 0) begin
               check_eq({nm, ".addr"}, acc_addr, addr);
               check_eq({nm, ".wr"}, 32'(acc_wr), 32'(op[3]));
               check_eq({nm, ".size"}, 32'(acc_size), 32'(x_size));
               check_eq({nm, ".wstrb"}, 32'(acc_wstrb), 32'(x_wstrb));
               if (op[3]) check_eq({nm, ".wdata"}, acc_wdata, x_wdata);
            end
            done = 1;
         end
      end
      flush = 1'b0;
      ext_stall = 1'b0;
      check_eq({nm, ".retired"}, 32'(done), 32'd1);
   endtask

   localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001, LHU = 6'b100101,
                          LW = 6'b100011, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
   localparam logic [3:0] C_LD = 4'b1010, C_ST = 4'b0100, C_ALU = 4'b0010;

   initial begin
      drive_bubble();
      repeat (3) @(negedge clk);
      check_eq("rst.pc", pcM, RPC);
      check_eq("rst.req", 32'(data_req), 32'd0);
      check_eq("rst.stall", 32'(stall_mem), 32'd0);
      check_eq("rst.res", resultM, 32'd0);
      check_eq("rst.rw", 32'(regwriteM), 32'd0);
      check_eq("rst.exc", 32'(exception_codeM), 32'd0);
      rst = 1'b0;

      //    name      op   ctrl   addr          wdata         exc    rdata         a  d  cr res           xexc   rw  n  wstrb    xwdata        hold fl
      do_op("sw",    SW,  C_ST,  32'h80001004, 32'hdeadbeef, 8'h00, 32'h0,       2, 1, 1, 32'h80001004, 8'h00, 0, 1, 4'b1111, 32'hdeadbeef, 0, 0);
      do_op("lb",    LB,  C_LD,  32'h80001003, 32'h0,       8'h00, 32'h80ff1234, 0, 1, 1, 32'hffffff80, 8'h00, 1, 1, 4'b0000, 32'h0,       0, 0);
      do_op("lbu",   LBU, C_LD,  32'h80001003, 32'h0,       8'h00, 32'h80ff1234, 0, 1, 1, 32'h00000080, 8'h00, 1, 1, 4'b0000, 32'h0,       0, 0);
      do_op("lh",    LH,  C_LD,  32'h80001002, 32'h0,       8'h00, 32'h80ff1234, 0, 1, 1, 32'hffff80ff, 8'h00, 1, 1, 4'b0000, 32'h0,       0, 0);
      do_op("lhu",   LHU, C_LD,  32'h80001000, 32'h0,       8'h00, 32'h80ff9234, 1, 2, 1, 32'h00009234, 8'h00, 1, 1, 4'b0000, 32'h0,       0, 0);
      do_op("lb1",   LB,  C_LD,  32'h80001001, 32'h0,       8'h00, 32'h80ff1234, 0, 1, 1, 32'h00000012, 8'h00, 1, 1, 4'b0000, 32'h0,       0, 0);
      do_op("lw",    LW,  C_LD,  32'h80001008, 32'h0,       8'h00, 32'hcafef00d, 0, 2, 1, 32'hcafef00d, 8'h00, 1, 1, 4'b0000, 32'h0,       0, 0);
      do_op("ades",  SH,  4'b0110, 32'h80001001, 32'h1111, 8'h00, 32'h0,       0, 1, 1, 32'h80001001, 8'h40, 0, 0, 4'b0000, 32'h0,       0, 0);
      do_op("adel_w", LW, C_LD,  32'h80001002, 32'h0,       8'h00, 32'h0,       0, 1, 0, 32'h0,        8'h20, 0, 0, 4'b0000, 32'h0,       0, 0);
      do_op("adel_h", LH, C_LD,  32'h80001003, 32'h0,       8'h00, 32'h0,       0, 1, 0, 32'h0,        8'h20, 0, 0, 4'b0000, 32'h0,       0, 0);
      do_op("hold",  LW,  C_LD,  32'h8000100c, 32'h0,       8'h00, 32'h12345678, 1, 1, 1, 32'h12345678, 8'h00, 1, 1, 4'b0000, 32'h0,       3, 0);
      do_op("flush", LW,  C_LD,  32'h80001010, 32'h0,       8'h00, 32'h0badf00d, 0, 3, 1, 32'h0,        8'h00, 0, 1, 4'b0000, 32'h0,       0, 1);
      do_op("sw2",   SW,  C_ST,  32'h80001014, 32'h11223344, 8'h00, 32'h0,       0, 1, 1, 32'h80001014, 8'h00, 0, 1, 4'b1111, 32'h11223344, 0, 0);
      do_op("sb2",   SB,  C_ST,  32'h80001002, 32'h000000a5, 8'h00, 32'h0,       0, 1, 1, 32'h80001002, 8'h00, 0, 1, 4'b0100, 32'ha5a5a5a5, 0, 0);
      do_op("sb0",   SB,  C_ST,  32'h80001000, 32'h0000003c, 8'h00, 32'h0,       1, 1, 1, 32'h80001000, 8'h00, 0, 1, 4'b0001, 32'h3c3c3c3c, 0, 0);
      do_op("sh2",   SH,  C_ST,  32'h80001002, 32'h0000beef, 8'h00, 32'h0,       0, 2, 1, 32'h80001002, 8'h00, 0, 1, 4'b1100, 32'hbeefbeef, 0, 0);
      do_op("sh0",   SH,  C_ST,  32'h80001000, 32'h00001234, 8'h00, 32'h0,       0, 1, 1, 32'h80001000, 8'h00, 0, 1, 4'b0011, 32'h12341234, 0, 0);
      do_op("ov_sw", SW,  C_ST,  32'h80001018, 32'h55555555, 8'h10, 32'h0,       0, 1, 1, 32'h80001018, 8'h10, 0, 0, 4'b0000, 32'h0,       0, 0);
      do_op("sys_lw", LW, C_LD,  32'h8000101c, 32'h0,       8'h04, 32'h0,       0, 1, 0, 32'h0,        8'h04, 1, 0, 4'b0000, 32'h0,       0, 0);
      do_op("alu",   6'b000000, C_ALU, 32'h12345678, 32'h0, 8'h00, 32'h0,       0, 1, 1, 32'h12345678, 8'h00, 1, 0, 4'b0000, 32'h0,       0, 0);

      repeat (5) @(negedge clk);
      check_eq("end.total_acc", 32'(n_acc), 32'(tot_acc));
      check_eq("end.req", 32'(data_req), 32'd0);
      check_eq("end.stall", 32'(stall_mem), 32'd0);
      check_eq("end.sbq_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute-stage outputs: ALU result, store data, memory opcode, controls, writereg, pc, exception code and delay-slot flag.
- Performs load/store accesses over an SRAM-like split address/data handshake to the data bus bridge. Does byte/halfword lane alignment and load sign/zero extension, and detects address-error exceptions.
- Produces resultM/writeregM for forwarding and writeback, and stall_mem for the hazard unit.

Parameters:
- RESET_PC, 32'hbfc00000, pc value loaded into the stage register on reset/flush.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold stage registers (from hazard unit)
- flush  in  1  squash stage contents (exception/eret)
- aluout  in  32  execute result / effective address
- mem_write_data  in  32  forwarded rt value for stores
- writereg  in  5  destination register
- pc  in  32  instruction pc
- opE  in  6  primary opcode
- controls  in  4  {memtoreg, memwrite, regwrite, cp0/hilo passthrough}
- exception_code  in  8  bits: 0 eret, 1 break, 2 syscall, 3 ri, 4 overflow
- is_in_slot  in  1  delay-slot flag
- data_req  out  1  request valid
- data_wr  out  1  1=store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  byte address
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte enables for stores
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  response/ack valid
- data_rdata  in  32  load data
- resultM  out  32  load value or aluout
- writeregM  out  5  destination register
- regwriteM  out  1  register write enable (0 on address error)
- pcM  out  32  stage pc
- exception_codeM  out  8  input code plus bit 5 AdEL, bit 6 AdES
- badvaddrM  out  32  faulting address
- is_in_slotM  out  1  delay-slot flag
- stall_mem  out  1  memory access not yet complete

Behaviour:
- Stage registers:
  - rst: pc=RESET_PC, all others 0.
  - flush: same as rst, except is_in_slot is kept.
  - ~stall: load the inputs.
  - stall: hold.
  - Priority: rst > flush > stall.
- Opcode decode on opE:
  - Loads: 100000 lb, 100100 lbu, 100001 lh, 100101 lhu, 100011 lw.
  - Stores: 101000 sb, 101001 sh, 101011 sw.
  - An access occurs only if memtoreg|memwrite is set, the op is a valid load/store, the input exception code is 0, and there is no address error.
- Address error:
  - Halfword with addr[0]!=0, or word with addr[1:0]!=0.
  - Load sets bit 5, store sets bit 6. badvaddrM=aluout. No request is issued. regwriteM=0.
  - With no error, badvaddrM=0.
- Store data:
  - sb: wdata={4{b}}, wstrb=1<<addr[1:0].
  - sh: wdata={2{h}}, wstrb=addr[1]?1100:0011.
  - sw: wstrb=1111.
  - Loads: wstrb=0000.
- data_addr=aluout (not word-masked). data_size from op.
- FSM states and transitions:
  - IDLE → REQ when a new access is present in the stage and not yet done.
  - REQ: data_req=1, addr/size/wdata stable. On addr_ok → WAIT (data_req=0 the next cycle).
  - WAIT: on data_ok → DONE; rdata is latched into rdata_buf in that same cycle.
  - DONE: held while stall=1, so the access is never reissued. → IDLE when the stage registers reload (~stall) or on flush.
  - A flush arriving while in WAIT, or while in REQ after addr_ok, → DRAIN. DRAIN discards the next data_ok, then → IDLE. New requests are blocked while in DRAIN.
  - Flush in REQ before addr_ok → IDLE, request dropped.
  - addr_ok and data_ok in the same cycle as the handshake completes: go straight to DONE.
- stall_mem = (access pending and not in DONE and no data_ok this cycle) | DRAIN. Load data is usable the same cycle data_ok rises (combinational from data_rdata).
- Load extension:
  - Select the byte/half by addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - lw: raw word.
- resultM = memtoreg ? extended load : aluout.
- writeregM, pcM, is_in_slotM pass through from the stage registers.
- regwriteM = regwrite & ~address-error.
- rst mid-access: FSM → IDLE immediately. The bus bridge is reset by the same rst.

Test Plan:
- sw aluout=0x80001004, data=0xdeadbeef, addr_ok after 2 cycles, data_ok 1 cycle later → data_req high 3 cycles, wstrb=1111, stall_mem high until the data_ok cycle, single request only.
- lb addr=0x80001003, rdata=0x80ff1234 → resultM=0xffffff80. Same with lbu → 0x00000080. lh addr ..02 → 0xffff80ff.
- sh addr=0x80001001 → no data_req, exception_codeM bit6=1, badvaddrM=0x80001001, regwriteM=0, stall_mem=0.
- lw, then external stall held 3 cycles after data_ok → FSM stays DONE, resultM stable, no second request.
- flush in WAIT of a lw → DRAIN, stall_mem stays 1 until data_ok; that data is dropped; next sw issues only after the drain.
- Input exception_code=0x10 (overflow) with memwrite=1 → no request, code passes through unchanged.
